// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control: latches an opcode and sequences FETCH/DECODE/EXEC/MEM/WB with per-state strobes.
// Latency handshake->FETCH: CBZ 3, R-type 4, STUR 4+W, LDUR 5+W (W = MEM cycles with mem_ready low).
// Backpressure: instr_ready high only in FETCH; MEM holds its strobe until mem_ready. MULTICYCLE_CTRL_EXC_EN adds sticky EXC.
module multicycle_ctrl #(
   parameter int OP_WIDTH    = 11,
   parameter int ALUOP_WIDTH = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [OP_WIDTH-1:0]    Op,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic                   mem_ready,
   output logic                   Reg2Loc,
   output logic                   ALUSrc,
   output logic                   MemtoReg,
   output logic                   RegWrite,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   Branch,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic                   IRWrite,
   output logic [CNT_WIDTH-1:0]   retired,
   output logic [2:0]             state_o
`ifdef MULTICYCLE_CTRL_EXC_EN
   ,
   output logic                   exc
`endif
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] EXC    = 3'd5;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [10:0] op_q;
   logic        retire;
   logic        accept;
   logic        is_ldur, is_stur, is_cbz, is_rtype, op_valid;
   logic        dec_active;
   logic [1:0]  alu_op2;

   // Only the low 11 opcode bits participate in decode.
   assign is_ldur  = (op_q == 11'b11111000010);
   assign is_stur  = (op_q == 11'b11111000000);
   assign is_cbz   = (op_q[10:3] == 8'b10110100);
   assign is_rtype = (op_q == 11'b10001011000) || (op_q == 11'b11001011000) ||
                     (op_q == 11'b10001010000) || (op_q == 11'b10101010000);
   assign op_valid = is_ldur | is_stur | is_cbz | is_rtype;

   assign accept      = (state == FETCH) && instr_valid;
   assign instr_ready = (state == FETCH);
   assign state_o     = state;

   // Next-state sequencing and retire detection.
   always_comb begin
      state_nxt = FETCH;
      retire    = 1'b0;
      case (state)
         FETCH:  state_nxt = instr_valid ? DECODE : FETCH;
`ifdef MULTICYCLE_CTRL_EXC_EN
         DECODE: state_nxt = op_valid ? EXEC : EXC;
         EXC:    state_nxt = EXC;
`else
         DECODE: state_nxt = op_valid ? EXEC : FETCH;
`endif
         EXEC: begin
            if (is_cbz) begin
               state_nxt = FETCH;
               retire    = 1'b1;
            end else if (is_ldur || is_stur) begin
               state_nxt = MEM;
            end else begin
               state_nxt = WB;
            end
         end
         MEM: begin
            if (!mem_ready) begin
               state_nxt = MEM;
            end else if (is_ldur) begin
               state_nxt = WB;
            end else begin
               state_nxt = FETCH;
               retire    = 1'b1;
            end
         end
         WB: begin
            state_nxt = FETCH;
            retire    = 1'b1;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // State, opcode latch and retired counter; reset aborts any in-flight instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= FETCH;
         op_q    <= '0;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q <= Op[10:0];
         end
         if (retire) begin
            retired <= retired + CNT_WIDTH'(1);
         end
      end
   end

   // Decode-level controls are held from DECODE until the return to FETCH.
   always_comb begin
      dec_active = (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);
      alu_op2    = 2'b00;
      if (is_rtype) begin
         alu_op2 = 2'b10;
      end else if (is_cbz) begin
         alu_op2 = 2'b01;
      end
      Reg2Loc  = dec_active && (is_stur || is_cbz);
      ALUSrc   = dec_active && (is_ldur || is_stur);
      MemtoReg = dec_active && is_ldur;
      ALUOp    = dec_active ? ALUOP_WIDTH'(alu_op2) : '0;
   end

   // Per-state strobes.
   always_comb begin
      IRWrite  = accept;
      Branch   = (state == EXEC) && is_cbz;
      MemRead  = (state == MEM) && is_ldur;
      MemWrite = (state == MEM) && is_stur;
      RegWrite = (state == WB);
   end

`ifdef MULTICYCLE_CTRL_EXC_EN
   assign exc = (state == EXC);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected control words from a small sequence model, table of instructions.
// Two instances share stimulus: default counter width and CNT_WIDTH=2 for wrap.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [2:0]  state;
      logic        instr_ready;
      logic        irwrite;
      logic        reg2loc;
      logic        alusrc;
      logic        memtoreg;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        branch;
      logic [1:0]  aluop;
      logic [15:0] retired;
      logic [1:0]  retired2;
   } ctl_t;

   typedef struct {
      logic        v;
      logic [10:0] op;
      logic        mr;
      ctl_t        e;
   } step_t;

   typedef struct {
      logic [10:0] op;
      int          w;
      int          lat;
      int          ret;
   } vec_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_BAD  = 11'b11111111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] Op;
   logic        instr_valid, mem_ready;
   logic        instr_ready, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, IRWrite;
   logic [1:0]  ALUOp;
   logic [15:0] retired;
   logic [2:0]  state_o;
   logic        instr_ready2, Reg2Loc2, ALUSrc2, MemtoReg2, RegWrite2, MemRead2, MemWrite2, Branch2, IRWrite2;
   logic [1:0]  ALUOp2;
   logic [1:0]  retired2;
   logic [2:0]  state_o2;
`ifdef MULTICYCLE_CTRL_EXC_EN
   logic        exc, exc2;
`endif

   int    n_assert = 0;
   int    n_fail   = 0;
   int    mret     = 0;
   step_t step_q[$];
   ctl_t  exp_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Op(Op), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .mem_ready(mem_ready), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
      .ALUOp(ALUOp), .IRWrite(IRWrite), .retired(retired), .state_o(state_o)
`ifdef MULTICYCLE_CTRL_EXC_EN
      , .exc(exc)
`endif
   );

   multicycle_ctrl #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .Op(Op), .instr_valid(instr_valid), .instr_ready(instr_ready2),
      .mem_ready(mem_ready), .Reg2Loc(Reg2Loc2), .ALUSrc(ALUSrc2), .MemtoReg(MemtoReg2),
      .RegWrite(RegWrite2), .MemRead(MemRead2), .MemWrite(MemWrite2), .Branch(Branch2),
      .ALUOp(ALUOp2), .IRWrite(IRWrite2), .retired(retired2), .state_o(state_o2)
`ifdef MULTICYCLE_CTRL_EXC_EN
      , .exc(exc2)
`endif
   );

   task automatic check_eq(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic ctl_t mk(input logic [2:0] st, input logic r2l, input logic asrc,
                               input logic m2r, input logic [1:0] aop);
      ctl_t e;
      e          = '0;
      e.state    = st;
      e.instr_ready = (st == 3'd0);
      e.reg2loc  = r2l;
      e.alusrc   = asrc;
      e.memtoreg = m2r;
      e.aluop    = aop;
      e.retired  = 16'(mret);
      e.retired2 = 2'(mret);
      return e;
   endfunction

   task automatic push(input logic v, input logic [10:0] op, input logic mr, input ctl_t e);
      step_t s;
      s.v = v; s.op = op; s.mr = mr; s.e = e;
      step_q.push_back(s);
   endtask

   // Expected per-cycle sequence for one instruction starting at its FETCH handshake.
   task automatic gen(input logic [10:0] op, input int w);
      logic ld, st, cb, rt, r2l, asrc, m2r;
      logic [1:0] aop;
      ctl_t e;
      ld   = (op == OP_LDUR);
      st   = (op == OP_STUR);
      cb   = (op[10:3] == 8'b10110100);
      rt   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
      r2l  = st | cb;
      asrc = ld | st;
      m2r  = ld;
      aop  = rt ? 2'b10 : (cb ? 2'b01 : 2'b00);
      e = mk(3'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      e.irwrite = 1'b1;
      push(1'b1, op, 1'($urandom_range(0, 1)), e);
      push(1'($urandom_range(0, 1)), 11'($urandom), 1'($urandom_range(0, 1)),
           mk(3'd1, r2l, asrc, m2r, aop));
      if (!(ld || st || cb || rt)) return;
      e = mk(3'd2, r2l, asrc, m2r, aop);
      e.branch = cb;
      push(1'($urandom_range(0, 1)), 11'($urandom), 1'($urandom_range(0, 1)), e);
      if (cb) begin
         mret++;
         return;
      end
      if (ld || st) begin
         for (int k = 0; k <= w; k++) begin
            e = mk(3'd3, r2l, asrc, m2r, aop);
            e.memread  = ld;
            e.memwrite = st;
            push(1'($urandom_range(0, 1)), 11'($urandom), (k == w), e);
         end
         if (st) begin
            mret++;
            return;
         end
      end
      e = mk(3'd4, r2l, asrc, m2r, aop);
      e.regwrite = 1'b1;
      push(1'($urandom_range(0, 1)), 11'($urandom), 1'($urandom_range(0, 1)), e);
      mret++;
   endtask

   // Drive queued steps; each expectation is pushed when driven and popped when sampled.
   task automatic apply(output int lat);
      step_t s;
      ctl_t  a, x;
      int    idx;
      lat = 0;
      idx = 0;
      while (step_q.size() > 0) begin
         s = step_q.pop_front();
         instr_valid = s.v;
         Op          = s.op;
         mem_ready   = s.mr;
         exp_q.push_back(s.e);
         @(negedge clk);
         a = {state_o, instr_ready, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead,
              MemWrite, Branch, ALUOp, retired, retired2};
         x = exp_q.pop_front();
         n_assert++;
         if (a !== x) begin
            n_fail++;
            $display("FAIL cycle%0d_ctl: got %h expected %h", idx, a, x);
         end
         if (idx == 0 || state_o != 3'd0) lat++;
         idx++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int m0, lat;
      m0 = mret;
      gen(v.op, v.w);
      apply(lat);
      check_eq({name, "_latency"}, lat, v.lat);
      check_eq({name, "_retired"}, int'(retired), (m0 + v.ret) % 65536);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      vec_t add_v;
      int   lat;
      int   exp2[5];
      tbl[0] = '{OP_ADD,  0, 4, 1};
      tbl[1] = '{OP_LDUR, 2, 7, 1};
      tbl[2] = '{OP_STUR, 0, 4, 1};
      tbl[3] = '{11'b10110100111, 0, 3, 1};
      tbl[4] = '{OP_SUB,  0, 4, 1};
      tbl[5] = '{OP_AND,  0, 4, 1};
      tbl[6] = '{OP_ORR,  0, 4, 1};
      tbl[7] = '{OP_LDUR, 0, 5, 1};
      tbl[8] = '{OP_STUR, 3, 7, 1};
      tbl[9] = '{11'b10110100000, 0, 3, 1};
      add_v  = '{OP_ADD, 0, 4, 1};
      exp2   = '{1, 2, 3, 0, 1};

      // Reset state while reset is held and the clock toggles.
      reset = 1'b0; instr_valid = 1'b0; Op = '0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      push(1'b0, 11'($urandom), 1'b1, mk(3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      push(1'b0, 11'($urandom), 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      apply(lat);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i]);
      end

`ifdef MULTICYCLE_CTRL_EXC_EN
      // Invalid opcode: sticky EXC, no handshake accepted, nothing retires.
      instr_valid = 1'b1; Op = OP_BAD;
      @(posedge clk); #1;
      Op = OP_ADD;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("exc_state", int'(state_o), 5);
         check_eq("exc_flag", int'(exc), 1);
         check_eq("exc_ready", int'(instr_ready), 0);
         check_eq("exc_irwrite", int'(IRWrite), 0);
         check_eq("exc_retired", int'(retired), mret % 65536);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      check_eq("exc_cleared", int'(exc), 0);
      @(posedge clk); #1;
      reset = 1'b1; instr_valid = 1'b0;
      mret = 0;
`else
      // Invalid opcode behaves as a NOP: DECODE then FETCH, not counted.
      run_vec("invalid", '{OP_BAD, 0, 2, 0});
`endif

      // Reset asserted mid-MEM aborts the load immediately.
      instr_valid = 1'b1; Op = OP_LDUR; mem_ready = 1'b0;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      #2;
      check_eq("mem_state", int'(state_o), 3);
      check_eq("mem_read", int'(MemRead), 1);
      reset = 1'b0;
      #1;
      check_eq("rst_state", int'(state_o), 0);
      check_eq("rst_memread", int'(MemRead), 0);
      check_eq("rst_ready", int'(instr_ready), 1);
      check_eq("rst_retired", int'(retired), 0);
      check_eq("rst_retired2", int'(retired2), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      mret = 0;

      // Five ADDs: narrow counter wraps 1,2,3,0,1.
      for (int i = 0; i < 5; i++) begin
         run_vec($sformatf("add%0d", i), add_v);
         check_eq($sformatf("wrap%0d", i), int'(retired2), exp2[i]);
      end

      // Idle FETCH with valid low.
      push(1'b0, 11'($urandom), 1'b1, mk(3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
      apply(lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
